// File: rtl/moore_pkg.sv
// Shared state encoding and transition/output functions for the two-phase Moore FSM.
// The same functions drive the RTL and the reference model in the bench.
package moore_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    // With minimise set, S4 is folded into S3 and its encoding becomes unused.
    function automatic state_t next_state(state_t s, logic x, bit minimise);
        state_t n;
        n = S0;
        case (s)
            S0: n = x ? S2 : S1;
            S1: n = x ? S3 : S1;
            S2: n = x ? (minimise ? S3 : S4) : S2;
            S3: n = x ? S0 : S5;
            S4: n = (x || minimise) ? S0 : S5;
            S5: n = S0;
            default: n = S0;
        endcase
        return n;
    endfunction

    function automatic logic out_of(state_t s);
        logic o;
        o = 1'b0;
        case (s)
            S1, S2, S5: o = 1'b1;
            default: o = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/moore_variants.sv
// Positional-order wrappers (y, x, clk, n_reset) for the full and minimised machines.
module moore_v1 (
    output logic y,
    input  logic x,
    input  logic clk,
    input  logic n_reset
);
    moore_fsm #(.MINIMISE(1'b0)) u_fsm (
        .clk     (clk),
        .n_reset (n_reset),
        .x       (x),
        .y       (y)
    );
endmodule

module moore_v2 (
    output logic y,
    input  logic x,
    input  logic clk,
    input  logic n_reset
);
    moore_fsm #(.MINIMISE(1'b1)) u_fsm (
        .clk     (clk),
        .n_reset (n_reset),
        .x       (x),
        .y       (y)
    );
endmodule

// File: rtl/moore_fsm.sv
// Six-state Moore FSM that advances once per two clocks: a sample edge loads ns,
// the following commit edge moves ns into state. y decodes state only.
module moore_fsm
    import moore_pkg::*;
#(
    parameter bit MINIMISE = 1'b0
) (
    input  logic clk,
    input  logic n_reset,
    input  logic x,
    output logic y
);

    state_t state;
    state_t ns;
    logic   phase;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S0;
            ns    <= S0;
            phase <= 1'b0;
        end else if (!phase) begin
            ns    <= next_state(state, x, MINIMISE);
            phase <= 1'b1;
        end else begin
            state <= ns;
            phase <= 1'b0;
        end
    end

    // Decoded from the committed state alone, so x can never glitch y.
    assign y = out_of(state);

endmodule

// File: tb/tb_moore_fsm.sv
// Directed and random bench for both MINIMISE variants of moore_fsm.
module tb_moore_fsm;
    import moore_pkg::*;

    logic clk;
    logic n_reset;
    logic x;
    logic y0;
    logic y1;

    int n_cmp;
    int n_err;

    state_t r0;
    state_t r1;

    moore_fsm #(.MINIMISE(1'b0)) dut_full (
        .clk     (clk),
        .n_reset (n_reset),
        .x       (x),
        .y       (y0)
    );

    moore_fsm #(.MINIMISE(1'b1)) dut_min (
        .clk     (clk),
        .n_reset (n_reset),
        .x       (x),
        .y       (y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One FSM step: x held through the sample edge, y checked after the commit edge.
    task automatic step(input logic xv, input logic exp, input string tag);
        x = xv;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        r0 = next_state(r0, xv, 1'b0);
        r1 = next_state(r1, xv, 1'b1);
        chk({tag, "_full"}, {2'b0, y0}, {2'b0, exp});
        chk({tag, "_min"},  {2'b0, y1}, {2'b0, exp});
    endtask

    always @(negedge clk) begin
        chk("full_vs_min", {2'b0, y0}, {2'b0, y1});
    end

    initial begin
        logic xv;
        n_cmp   = 0;
        n_err   = 0;
        n_reset = 1'b0;
        x       = 1'b0;
        r0      = S0;
        r1      = S0;

        #2;
        chk("rst_y_full", {2'b0, y0}, 3'd0);
        chk("rst_y_min",  {2'b0, y1}, 3'd0);
        x = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_full", {2'b0, y0}, 3'd0);
        chk("rst_hold_min",  {2'b0, y1}, 3'd0);
        x = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;

        step(1'b0, 1'b1, "s0_to_s1");
        step(1'b0, 1'b1, "s1_loop");
        step(1'b1, 1'b0, "s1_to_s3");
        step(1'b0, 1'b1, "s3_to_s5");
        step(1'b1, 1'b0, "s5_to_s0_x1");

        step(1'b1, 1'b1, "s0_to_s2");
        step(1'b0, 1'b1, "s2_loop");
        step(1'b1, 1'b0, "s2_to_s4s3");
        step(1'b0, 1'b1, "s4s3_to_s5");
        step(1'b1, 1'b0, "s5_to_s0_b");

        step(1'b0, 1'b1, "to_s1_c");
        step(1'b1, 1'b0, "to_s3_c");
        step(1'b1, 1'b0, "s3_to_s0_x1");
        step(1'b0, 1'b1, "s0_after_s3");
        step(1'b1, 1'b0, "to_s3_d");
        step(1'b0, 1'b1, "to_s5_d");
        step(1'b0, 1'b0, "s5_to_s0_x0");

        step(1'b1, 1'b1, "to_s2_e");
        // Sample edge loads ns, then reset hits before the commit edge.
        x = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_s2_full", {2'b0, y0}, 3'd1);
        chk("pre_rst_s2_min",  {2'b0, y1}, 3'd1);
        n_reset = 1'b0;
        #1;
        chk("midstep_rst_full", {2'b0, y0}, 3'd0);
        chk("midstep_rst_min",  {2'b0, y1}, 3'd0);
        @(posedge clk);
        #1;
        chk("midstep_hold_full", {2'b0, y0}, 3'd0);
        chk("midstep_hold_min",  {2'b0, y1}, 3'd0);
        @(negedge clk);
        n_reset = 1'b1;
        r0 = S0;
        r1 = S0;
        step(1'b0, 1'b1, "post_rst_s1");

        for (int i = 0; i < 250; i++) begin
            xv = 1'($urandom_range(0, 1));
            x  = xv;
            @(posedge clk);
            #1;
            x = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            r0 = next_state(r0, xv, 1'b0);
            r1 = next_state(r1, xv, 1'b1);
            chk("rand_full", {2'b0, y0}, {2'b0, out_of(r0)});
            chk("rand_min",  {2'b0, y1}, {2'b0, out_of(r1)});
        end

        chk("unused6_next", next_state(state_t'(3'd6), 1'b1, 1'b0), S0);
        chk("unused7_next", next_state(state_t'(3'd7), 1'b0, 1'b1), S0);
        chk("unused7_out",  {2'b0, out_of(state_t'(3'd7))}, 3'd0);
        chk("min_s4_next",  next_state(S4, 1'b0, 1'b1), S0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
